// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the single-cycle MIPS core.
// Owns the PC, fetches over a req/ack instruction memory port, holds the
// word until the core accepts it, then selects PC+4, branch or jump target.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   imem_req, imem_addr   fetch request / address (address = pc)
//   imem_ack, imem_rdata  memory response, data valid only with ack
//   if_valid, if_ready    held-instruction handshake with the core
//   if_instr/if_pc/if_pc4 held instruction, its address, address+4
//   branch_taken/offset   branch redirect, sampled only at accept
//   jump/jump_index       jump redirect, sampled only at accept
//   instr_count           instructions accepted since reset (wraps)
//   fault                 sticky memory timeout flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] instr_count,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(IMEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        ack_ok;
    logic        accept;
    logic        timeout;

    // Ack only counts while a request is outstanding.
    assign ack_ok  = (state == S_REQ) && imem_ack;
    assign accept  = (state == S_HOLD) && if_ready;
    // An ack in the last allowed cycle beats the timeout.
    assign timeout = (state == S_REQ) && !imem_ack
                     && (wait_cnt == WAIT_LAST);

    assign br_tgt  = if_pc4
                     + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jmp_tgt = {if_pc4[31:28], jump_index, 2'b00};

    always_comb begin
        if (jump) begin
            next_pc = jmp_tgt;
        end else if (branch_taken) begin
            next_pc = br_tgt;
        end else begin
            next_pc = if_pc4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (ack_ok) begin
                    state_nxt = S_HOLD;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_HOLD: begin
                if (if_ready) begin
                    state_nxt = S_REQ;
                end
            end
            S_FAULT: state_nxt = S_FAULT;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if_valid = 1'b0;
        fault    = 1'b0;
        unique case (state)
            S_IDLE:  ;
            S_REQ:   imem_req = 1'b1;
            S_HOLD:  if_valid = 1'b1;
            S_FAULT: fault    = 1'b1;
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            if_instr    <= '0;
            if_pc       <= RESET_PC;
            if_pc4      <= RESET_PC + 32'd4;
            instr_count <= '0;
        end else begin
            if (ack_ok) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_pc4   <= pc + 32'd4;
            end else if ((state == S_REQ) && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (accept) begin
                pc          <= next_pc;
                instr_count <= instr_count + 32'd1;
                wait_cnt    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit.
// Memory and core are driven from one sequence; a PC/count model predicts.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic [31:0] instr_count;
    logic        fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_instr;

    fetch_unit #(
        .RESET_PC    (RPC),
        .IMEM_TIMEOUT(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .instr_count  (instr_count),
        .fault        (fault)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after 200000 time units");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural next PC: word offsets scaled by 4, jump keeps the
    // region nibble of the following instruction.
    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input bit br, input logic [15:0] off,
        input bit j, input logic [25:0] idx);
        logic [31:0] pc4;
        int so;
        pc4 = pc + 32'd4;
        so  = $signed(off);
        if (j) return (pc4 & 32'hF000_0000) | ({6'b0, idx} << 2);
        if (br) return pc4 + 32'(so * 4);
        return pc4;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic fetch(input int aw, input int hw, input bit br,
                         input logic [15:0] off, input bit j,
                         input logic [25:0] idx, output int rc);
        wait_req();
        rc = cyc;
        chk("req", 32'(imem_req), 1);
        chk("addr", imem_addr, m_pc);
        chk("valid_lo", 32'(if_valid), 0);
        for (int i = 0; i < aw; i++) begin
            @(negedge clock);
            chk("req_wait", 32'(imem_req), 1);
            chk("addr_wait", imem_addr, m_pc);
            chk("fault_wait", 32'(fault), 0);
        end
        m_instr    = $urandom;
        imem_rdata = m_instr;
        imem_ack   = 1'b1;
        @(negedge clock);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid", 32'(if_valid), 1);
        chk("instr", if_instr, m_instr);
        chk("if_pc", if_pc, m_pc);
        chk("if_pc4", if_pc4, m_pc + 32'd4);
        chk("req_hold", 32'(imem_req), 0);
        for (int i = 0; i < hw; i++) begin
            branch_taken  = 1'($urandom);
            jump          = 1'($urandom);
            branch_offset = 16'($urandom);
            jump_index    = 26'($urandom);
            @(negedge clock);
            chk("bp_valid", 32'(if_valid), 1);
            chk("bp_instr", if_instr, m_instr);
            chk("bp_pc", if_pc, m_pc);
            chk("bp_req", 32'(imem_req), 0);
            chk("bp_count", instr_count, m_cnt);
        end
        if_ready      = 1'b1;
        branch_taken  = br;
        branch_offset = off;
        jump          = j;
        jump_index    = idx;
        @(negedge clock);
        if_ready     = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        m_pc  = model_next(m_pc, br, off, j, idx);
        m_cnt = m_cnt + 32'd1;
        chk("count", instr_count, m_cnt);
        chk("valid_drop", 32'(if_valid), 0);
    endtask

    initial begin
        int c1, c2, c3, cx;
        m_pc    = RPC;
        m_cnt   = 0;
        m_instr = 0;

        repeat (3) @(negedge clock);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_pc", if_pc, RPC);
        chk("rst_pc4", if_pc4, RPC + 32'd4);
        chk("rst_count", instr_count, 0);
        chk("rst_fault", 32'(fault), 0);

        reset = 1'b0;
        @(negedge clock);
        chk("first_req", 32'(imem_req), 1);

        fetch(0, 0, 0, 16'h0, 0, 26'h0, c1);
        fetch(0, 0, 0, 16'h0, 0, 26'h0, c2);
        chk("period1", 32'(c2 - c1), 2);
        fetch(0, 0, 1, 16'hFFFE, 0, 26'h0, c3);
        chk("period2", 32'(c3 - c2), 2);
        fetch(0, 5, 0, 16'h0, 0, 26'h0, cx);
        fetch(0, 0, 1, 16'h0003, 0, 26'h0, cx);
        fetch(1, 0, 1, 16'hFFFD, 0, 26'h0, cx);
        fetch(2, 0, 1, 16'h0004, 1, 26'h0100040, cx);

        wait_req();
        chk("mid_addr", imem_addr, m_pc);
        repeat (3) @(negedge clock);
        chk("mid_count", instr_count, 7);
        #2;
        reset    = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 0);
        chk("async_count", instr_count, 0);
        chk("async_addr", imem_addr, RPC);
        chk("async_valid", 32'(if_valid), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        imem_ack = 1'b0;
        chk("post_rst_req", 32'(imem_req), 1);
        chk("post_rst_addr", imem_addr, RPC);
        chk("post_rst_valid", 32'(if_valid), 0);
        m_pc  = RPC;
        m_cnt = 0;

        fetch(0, 0, 0, 16'h0, 1, 26'h0, cx);
        fetch(0, 0, 1, 16'hFFFE, 0, 26'h0, cx);
        fetch(0, 0, 0, 16'h0, 0, 26'h0, cx);

        for (int k = 0; k < 24; k++) begin
            fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom), 16'($urandom), 1'($urandom),
                  26'($urandom), cx);
        end

        wait_req();
        chk("to_addr", imem_addr, m_pc);
        repeat (3) begin
            @(negedge clock);
            chk("to_req", 32'(imem_req), 1);
            chk("to_nofault", 32'(fault), 0);
        end
        @(negedge clock);
        chk("to_fault", 32'(fault), 1);
        chk("to_req_off", 32'(imem_req), 0);
        chk("to_valid", 32'(if_valid), 0);
        chk("to_instr", if_instr, m_instr);
        imem_ack = 1'b1;
        if_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("sticky_fault", 32'(fault), 1);
            chk("sticky_req", 32'(imem_req), 0);
            chk("sticky_valid", 32'(if_valid), 0);
            chk("sticky_count", instr_count, m_cnt);
        end
        imem_ack = 1'b0;
        if_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle MIPS core. It owns the program counter and requests instructions from a handshaked instruction memory that may take one or more cycles to answer. It holds each fetched instruction until the core consumes it, then computes the next PC from three sources: sequential PC+4, the branch target, or the jump target supplied by the core. It also flags a fault when the instruction memory stops responding.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- IMEM_TIMEOUT, 16, number of REQ cycles without `imem_ack` before the fetch faults; legal range 1..255.

- clock  in  1  single clock for the block; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; stable while `imem_req`=1.
- imem_ack  in  1  memory response; `imem_rdata` is valid only in the cycle `imem_ack`=1.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  `if_instr`/`if_pc`/`if_pc4` hold a valid instruction.
- if_ready  in  1  core consumes the instruction this cycle.
- if_instr  out  32  held instruction.
- if_pc  out  32  address of `if_instr`.
- if_pc4  out  32  `if_pc`+4.
- branch_taken  in  1  Branch AND Zero for `if_instr`.
- branch_offset  in  16  `if_instr[15:0]`.
- jump  in  1  `if_instr` is a jump.
- jump_index  in  26  `if_instr[25:0]`.
- instr_count  out  32  number of instructions consumed since reset; wraps modulo 2^32.
- fault  out  1  sticky fetch timeout flag.

## Operation
- States:
  - IDLE: entered on reset.
  - REQ: request outstanding.
  - HOLD: instruction held for the core.
  - FAULT: terminal until reset.
- IDLE → REQ unconditionally on the first edge after reset deasserts.
- REQ:
  - Outputs: `imem_req`=1, `imem_addr`=pc.
  - On `imem_ack`=1: capture `imem_rdata` into `if_instr`, load `if_pc`=pc and `if_pc4`=pc+4, go to HOLD.
  - Otherwise: `wait_cnt`++.
  - If `wait_cnt`==IMEM_TIMEOUT-1 and no ack: go to FAULT.
- HOLD:
  - Outputs: `if_valid`=1, `imem_req`=0.
  - On `if_ready`=1 (accept):
    - pc ← next_pc.
    - `instr_count`++.
    - `wait_cnt` ← 0.
    - Go to REQ.
  - With `if_ready`=0: all if_* outputs are held unchanged.
- next_pc, evaluated at accept only (redirect inputs are ignored in all other cycles):
  - `jump`=1: {`if_pc4[31:28]`, `jump_index`, 2'b00}. Jump has priority over `branch_taken`.
  - else `branch_taken`=1: `if_pc4` + ({{14{`branch_offset[15]`}}, `branch_offset`, 2'b00}), 32-bit modulo arithmetic.
  - else: `if_pc4`.
- FAULT:
  - Outputs: `fault`=1, `imem_req`=0, `if_valid`=0; `if_instr` keeps its last value.
  - Leaves only on reset.
- PC arithmetic wraps: pc 32'hFFFF_FFFC gives `if_pc4`=0.

## Timing
- Reset values (immediate on assertion):
  - state IDLE, pc = RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_instr`=0, `if_pc`=RESET_PC, `if_pc4`=RESET_PC+4.
  - `instr_count`=0, `fault`=0, `wait_cnt`=0.
- All outputs are decoded from registers; there is no combinational input→output path.
- Latency:
  - First `imem_req` in the first cycle after the IDLE edge.
  - Ack at edge N: `if_valid`=1 from edge N.
  - Accept at edge M: next `imem_req` from edge M.
  - Peak throughput: 1 instruction per 2 cycles (zero-wait memory, `if_ready` tied high).
- Simultaneous events:
  - Ack on the same edge the timeout would fire: ack wins, no fault.
  - Ack outside REQ is ignored.
- Reset mid-operation: a pending request is abandoned; an ack arriving during or after reset, before the next REQ, is ignored.

## Test plan
- Reset/sequential flow:
  - Stimulus: RESET_PC=32'h0040_0000; hold reset, check all reset values; release; memory acks in the same cycle as each request; `if_ready`=1.
  - Required: `imem_addr` = 0x00400000, 0x00400004, 0x00400008, one request every 2 cycles; `instr_count` = 1, 2, 3.
- Backpressure:
  - Stimulus: `if_ready`=0 for 5 cycles while in HOLD.
  - Required: `if_valid`=1 and `if_instr`/`if_pc` stable; `imem_req`=0; `instr_count` unchanged; accept on cycle 6 resumes fetching.
- Branch:
  - Stimulus: accept at `if_pc`=0x00400008 with `branch_taken`=1, offset 16'hFFFE. Required: next `imem_addr`=0x00400004.
  - Stimulus: offset 16'h0003. Required: 0x00400018.
  - Stimulus: `branch_taken`=1 while `if_ready`=0. Required: no effect.
- Jump priority:
  - Stimulus: accept at `if_pc`=0x00400010 with `jump`=1, `jump_index`=26'h0100040, `branch_taken`=1, offset 16'h0004.
  - Required: next `imem_addr`=0x00400100.
- Timeout:
  - Stimulus: IMEM_TIMEOUT=4, `imem_ack` never asserted. Required: `fault`=1 after 4 REQ cycles, `imem_req`=0; later acks ignored until reset.
  - Stimulus: ack in the 4th REQ cycle. Required: no fault, `if_valid`=1.
- Asynchronous reset mid-wait:
  - Stimulus: assert reset between clock edges during REQ (3 wait cycles elapsed, `instr_count`=7).
  - Required: `imem_req`=0 and `instr_count`=0 immediately; after release, the first request goes to RESET_PC.
